// File: rtl/mrd_pkg.sv
// Shared definitions for the MRD inverse datapath: controller state encoding,
// default pipeline latencies shared with M2V/V2V, and port-width helpers.
package mrd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MV1  = 3'd1,
    RJL  = 3'd2,
    MV2  = 3'd3,
    DOT  = 3'd4,
    UPD  = 3'd5,
    WR   = 3'd6,
    DONE = 3'd7
  } mrd_state_e;

  localparam int MRD_DIMENSION = 16;
  localparam int MRD_ITER_NUM  = 2;
  localparam int MRD_MV_LAT    = 2;
  localparam int MRD_VV_LAT    = 2;

  // Column index width; never narrower than one bit.
  function automatic int cw_of(input int dim);
    return (dim <= 2) ? 1 : $clog2(dim);
  endfunction

  function automatic int iw_of(input int iters);
    return (iters <= 1) ? 1 : $clog2(iters + 1);
  endfunction

  // Width that holds max(a,b)-1, the largest value the wait counter is loaded with.
  function automatic int lat_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mrd_inv_ctrl_lat_cnt.sv
// mrd_lat_cnt: loadable down-counter with a zero flag, used to time the
// M2V and V2V pipeline waits. Load wins over decrement; it stops at zero.
module mrd_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (load) begin
        cnt_d = load_val;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mrd_inv_ctrl.sv
// mrd_inv_ctrl: sequencer for the MRD column-wise inverse (A*m, rj latch, A*rj, dots, Mi update).
// Optional fenmu==0 guard is compiled in with the macro MRD_CTRL_ZDIV_CHK_EN.
module mrd_inv_ctrl
  import mrd_pkg::*;
#(
  parameter int  DIMENSION = MRD_DIMENSION,
  parameter int  ITER_NUM  = MRD_ITER_NUM,
  parameter int  MV_LAT    = MRD_MV_LAT,
  parameter int  VV_LAT    = MRD_VV_LAT,
  localparam int CW        = cw_of(DIMENSION),
  localparam int IW        = iw_of(ITER_NUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic          fenmu_zero,
  output logic          slc_sig1,
  output logic          slc_sig2,
  output logic          rj_ld,
  output logic          mi_ld,
  output logic          col_wr,
  output logic [CW-1:0] col_idx,
  output logic [IW-1:0] iter_idx,
  output logic          busy,
  output logic          done,
  output logic          degen
);

  // start is a level request with no ready: it is taken only in IDLE with en=1
  // and is otherwise dropped, never queued. Strobes are 1-cycle, gated by en.

  localparam int            LW    = lat_w(MV_LAT, VV_LAT);
  localparam logic [LW-1:0] MV_LD = LW'(MV_LAT - 1);
  localparam logic [LW-1:0] VV_LD = LW'(VV_LAT - 1);

  mrd_state_e    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          slc1_q, slc1_d;
  logic          cnt_load;
  logic [LW-1:0] cnt_val;
  logic          cnt_zero;
  logic          zdiv_hit;
  logic          last_iter;
  logic          last_col;

`ifdef MRD_CTRL_ZDIV_CHK_EN
  logic degen_q, degen_d;
  assign zdiv_hit = fenmu_zero;
  assign degen    = degen_q;
`else
  logic unused_fenmu_zero;
  assign unused_fenmu_zero = fenmu_zero;
  assign zdiv_hit          = 1'b0;
  assign degen             = 1'b0;
`endif

  assign last_iter = (int'(iter_q) == ITER_NUM - 1);
  assign last_col  = (int'(col_q) == DIMENSION - 1);

  mrd_lat_cnt #(
    .W(LW)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      iter_q  <= '0;
      slc1_q  <= 1'b0;
`ifdef MRD_CTRL_ZDIV_CHK_EN
      degen_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      iter_q  <= iter_d;
      slc1_q  <= slc1_d;
`ifdef MRD_CTRL_ZDIV_CHK_EN
      degen_q <= degen_d;
`endif
    end
  end

  // Next state: everything holds while en is low; wait counters load on entry.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    iter_d   = iter_q;
    slc1_d   = slc1_q;
    cnt_load = 1'b0;
    cnt_val  = MV_LD;
`ifdef MRD_CTRL_ZDIV_CHK_EN
    degen_d  = degen_q;
`endif
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = MV1;
            cnt_load = 1'b1;
            cnt_val  = MV_LD;
`ifdef MRD_CTRL_ZDIV_CHK_EN
            degen_d  = 1'b0;
`endif
          end
        end
        MV1: begin
          if (cnt_zero) state_d = RJL;
        end
        RJL: begin
          state_d  = MV2;
          cnt_load = 1'b1;
          cnt_val  = MV_LD;
        end
        MV2: begin
          if (cnt_zero) begin
            state_d  = DOT;
            cnt_load = 1'b1;
            cnt_val  = VV_LD;
          end
        end
        DOT: begin
          if (cnt_zero) state_d = UPD;
        end
        UPD: begin
          if (zdiv_hit) begin
            // Degenerate column: keep Mi as is and write it out immediately.
            state_d = WR;
`ifdef MRD_CTRL_ZDIV_CHK_EN
            degen_d = 1'b1;
`endif
          end else begin
            slc1_d = 1'b1;
            if (!last_iter) begin
              iter_d   = iter_q + IW'(1);
              state_d  = MV1;
              cnt_load = 1'b1;
              cnt_val  = MV_LD;
            end else begin
              state_d = WR;
            end
          end
        end
        WR: begin
          iter_d = '0;
          slc1_d = 1'b0;
          if (last_col) begin
            state_d = DONE;
          end else begin
            col_d    = col_q + CW'(1);
            state_d  = MV1;
            cnt_load = 1'b1;
            cnt_val  = MV_LD;
          end
        end
        DONE: begin
          col_d   = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    slc_sig2 = 1'b0;
    rj_ld    = 1'b0;
    mi_ld    = 1'b0;
    col_wr   = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      MV2, DOT: slc_sig2 = 1'b1;
      RJL:      rj_ld    = en;
      UPD:      mi_ld    = en & ~zdiv_hit;
      WR:       col_wr   = en;
      DONE:     done     = en;
      default:  ;
    endcase
  end

  assign slc_sig1 = slc1_q;
  assign col_idx  = col_q;
  assign iter_idx = iter_q;
  assign busy     = (state_q != IDLE);

endmodule
